usb2_ep0_ctrl: RTL and testbench

Parametrised USB 2.0 endpoint-0 control-transfer engine: full SETUP / DATA / STATUS sequencing between the protocol layer and the device. Handles multi-packet IN data stages with `MAX_PKT` splitting, DATA0/DATA1 toggling, zero-length-packet termination, host-to-device vendor data stages and STALL. Sits between the packet protocol layer and an external descriptor ROM plus descriptor lookup map.

---
 rtl/usb2_ep0_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 tb/tb_usb2_ep0_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb2_ep0_ctrl.sv
// USB 2.0 endpoint-0 control transfer engine: SETUP decode, IN/OUT data
// stages with MAX_PKT splitting and DATA0/1 toggling, status and STALL.
module usb2_ep0_ctrl #(
    parameter int MAX_PKT  = 64,
    parameter int DESCR_AW = 8
) (
    input  logic                phy_clk,
    input  logic                reset_n,
    input  logic                rx_wren,
    input  logic [7:0]          rx_data,
    input  logic                rx_setup,
    input  logic                rx_commit,
    input  logic [6:0]          rx_len,
    output logic                rx_ready,
    input  logic [6:0]          tx_addr,
    output logic [7:0]          tx_q,
    output logic [6:0]          tx_len,
    output logic                tx_hasdata,
    output logic                tx_data1,
    input  logic                tx_ack,
    output logic                stall,
    output logic [15:0]         lut_wval,
    input  logic                lut_hit,
    input  logic [DESCR_AW-1:0] lut_base,
    input  logic [15:0]         lut_len,
    output logic [DESCR_AW-1:0] descr_addr,
    input  logic [7:0]          descr_q,
    output logic                vend_req_act,
    output logic [7:0]          vend_req_request,
    output logic [15:0]         vend_req_val,
    output logic [15:0]         vend_req_idx,
    output logic [15:0]         vend_req_len,
    output logic                vend_wr_en,
    output logic [7:0]          vend_wr_data,
    output logic [6:0]          dev_addr,
    output logic                configured
);
    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_LOOKUP, S_IN_DATA,
        S_OUT_DATA, S_STATUS_IN, S_STATUS_OUT, S_STALL
    } state_t;

    localparam logic [6:0] MPKT = 7'(MAX_PKT);

    state_t state_q, state_d;
    logic [7:0] sbuf_q [8];
    logic [7:0] sbuf_d [8];
    logic [3:0] idx_q, idx_d;
    logic [2:0] bm_q, bm_d;
    logic [7:0] breq_q, breq_d;
    logic [15:0] wval_q, wval_d, widx_q, widx_d, wlen_q, wlen_d;
    logic [16:0] rem_q, rem_d;
    logic [15:0] total_q, total_d, off_q, off_d;
    logic [DESCR_AW-1:0] base_q, base_d;
    logic use_rom_q, use_rom_d, tog_q, tog_d;
    logic [6:0] tx_len_q, tx_len_d;
    logic tx_hasdata_q, tx_hasdata_d, tx_data1_q, tx_data1_d;
    logic stall_q, stall_d, rx_ready_q, rx_ready_d;
    logic [7:0] inl_q, inl_d;
    logic vact_q, vact_d, vwen_q, vwen_d;
    logic [7:0] vreq_q, vreq_d, vwdat_q, vwdat_d;
    logic [15:0] vval_q, vval_d, vidx_q, vidx_d, vlen_q, vlen_d;
    logic [6:0] dev_addr_q, dev_addr_d, cfg_q, cfg_d;

    logic [6:0] pkt;
    logic [16:0] rem_sub, out_sub;
    logic [15:0] lmin;

    always_comb begin
        state_d      = state_q;
        sbuf_d       = sbuf_q;
        idx_d        = idx_q;
        bm_d         = bm_q;
        breq_d       = breq_q;
        wval_d       = wval_q;
        widx_d       = widx_q;
        wlen_d       = wlen_q;
        rem_d        = rem_q;
        total_d      = total_q;
        off_d        = off_q;
        base_d       = base_q;
        use_rom_d    = use_rom_q;
        tog_d        = tog_q;
        tx_len_d     = tx_len_q;
        tx_hasdata_d = tx_hasdata_q;
        tx_data1_d   = tx_data1_q;
        stall_d      = stall_q;
        vact_d       = 1'b0;
        vreq_d       = vreq_q;
        vval_d       = vval_q;
        vidx_d       = vidx_q;
        vlen_d       = vlen_q;
        vwen_d       = rx_wren && (state_q == S_OUT_DATA);
        vwdat_d      = rx_data;
        dev_addr_d   = dev_addr_q;
        cfg_d        = cfg_q;
        inl_d        = (breq_q == 8'h08 && tx_addr == 7'd0) ? {1'b0, cfg_q} : 8'h00;
        pkt          = (rem_q >= 17'(MAX_PKT)) ? MPKT : rem_q[6:0];
        rem_sub      = rem_q - 17'(tx_len_q);
        out_sub      = rem_q - 17'(rx_len);
        lmin         = (wlen_q < lut_len) ? wlen_q : lut_len;

        if (rx_wren && !idx_q[3]) begin
            sbuf_d[idx_q[2:0]] = rx_data;
            idx_d = idx_q + 4'd1;
        end
        if (rx_commit) idx_d = 4'd0;

        if (rx_commit && rx_setup) begin
            stall_d      = 1'b0;
            tx_hasdata_d = 1'b0;
            tx_len_d     = 7'd0;
            rem_d        = 17'd0;
            off_d        = 16'd0;
            tog_d        = 1'b1;
            use_rom_d    = 1'b0;
            if (rx_len == 7'd8) begin
                state_d = S_DECODE;
                bm_d    = sbuf_q[0][7:5];
                breq_d  = sbuf_q[1];
                wval_d  = {sbuf_q[3], sbuf_q[2]};
                widx_d  = {sbuf_q[5], sbuf_q[4]};
                wlen_d  = {sbuf_q[7], sbuf_q[6]};
            end else begin
                state_d = S_STALL;
                stall_d = 1'b1;
            end
        end else begin
            unique case (state_q)
                S_DECODE: begin
                    if (bm_q[1:0] == 2'b10) begin
                        vact_d = 1'b1;
                        vreq_d = breq_q;
                        vval_d = wval_q;
                        vidx_d = widx_q;
                        vlen_d = wlen_q;
                        if (!bm_q[2] && wlen_q != 16'd0) begin
                            state_d = S_OUT_DATA;
                            rem_d   = {1'b0, wlen_q};
                        end else begin
                            state_d = S_STATUS_IN;
                        end
                    end else if (bm_q[1:0] != 2'b00) begin
                        state_d = S_STALL;
                        stall_d = 1'b1;
                    end else begin
                        unique case (breq_q)
                            8'h06: state_d = S_LOOKUP;
                            8'h08: begin
                                state_d = S_IN_DATA;
                                rem_d   = (wlen_q == 16'd0) ? 17'd0 : 17'd1;
                                total_d = rem_d[15:0];
                            end
                            8'h00: begin
                                state_d = S_IN_DATA;
                                rem_d   = (wlen_q < 16'd2) ? {1'b0, wlen_q} : 17'd2;
                                total_d = rem_d[15:0];
                            end
                            8'h05, 8'h09, 8'h0B: state_d = S_STATUS_IN;
                            default: begin
                                state_d = S_STALL;
                                stall_d = 1'b1;
                            end
                        endcase
                    end
                end
                S_LOOKUP: begin
                    if (!lut_hit) begin
                        state_d = S_STALL;
                        stall_d = 1'b1;
                    end else begin
                        state_d   = S_IN_DATA;
                        rem_d     = {1'b0, lmin};
                        total_d   = lmin;
                        off_d     = 16'd0;
                        base_d    = lut_base;
                        use_rom_d = 1'b1;
                    end
                end
                S_IN_DATA: begin
                    // an OUT here is the host cutting the data stage short
                    if (rx_commit) begin
                        state_d      = S_IDLE;
                        tx_hasdata_d = 1'b0;
                    end else if (!tx_hasdata_q) begin
                        tx_hasdata_d = 1'b1;
                        tx_len_d     = pkt;
                        tx_data1_d   = tog_q;
                    end else if (tx_ack) begin
                        tx_hasdata_d = 1'b0;
                        off_d        = off_q + 16'(tx_len_q);
                        rem_d        = rem_sub;
                        tog_d        = !tog_q;
                        if (rem_sub == 17'd0 &&
                            !(tx_len_q == MPKT && total_q < wlen_q))
                            state_d = S_STATUS_OUT;
                    end
                end
                S_OUT_DATA: begin
                    if (rx_commit) begin
                        rem_d = out_sub;
                        if (out_sub[16] || out_sub == 17'd0 || rx_len < MPKT)
                            state_d = S_STATUS_IN;
                    end
                end
                S_STATUS_IN: begin
                    if (!tx_hasdata_q) begin
                        tx_hasdata_d = 1'b1;
                        tx_len_d     = 7'd0;
                        tx_data1_d   = 1'b1;
                    end else if (tx_ack) begin
                        tx_hasdata_d = 1'b0;
                        state_d      = S_IDLE;
                        if (bm_q[1:0] == 2'b00 && breq_q == 8'h05)
                            dev_addr_d = wval_q[6:0];
                        if (bm_q[1:0] == 2'b00 && breq_q == 8'h09)
                            cfg_d = wval_q[6:0];
                    end
                end
                S_STATUS_OUT: if (rx_commit) state_d = S_IDLE;
                S_IDLE, S_STALL: ;
                default: state_d = S_IDLE;
            endcase
        end

        rx_ready_d = (state_d == S_STALL) ||
                     (!rx_commit && state_d != S_DECODE && state_d != S_LOOKUP);
    end

    always_ff @(posedge phy_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            sbuf_q       <= '{default: 8'h00};
            idx_q        <= 4'd0;
            bm_q         <= 3'd0;
            breq_q       <= 8'h00;
            wval_q       <= 16'h0;
            widx_q       <= 16'h0;
            wlen_q       <= 16'h0;
            rem_q        <= 17'd0;
            total_q      <= 16'd0;
            off_q        <= 16'd0;
            base_q       <= '0;
            use_rom_q    <= 1'b0;
            tog_q        <= 1'b0;
            tx_len_q     <= 7'd0;
            tx_hasdata_q <= 1'b0;
            tx_data1_q   <= 1'b0;
            stall_q      <= 1'b0;
            rx_ready_q   <= 1'b1;
            inl_q        <= 8'h00;
            vact_q       <= 1'b0;
            vreq_q       <= 8'h00;
            vval_q       <= 16'h0;
            vidx_q       <= 16'h0;
            vlen_q       <= 16'h0;
            vwen_q       <= 1'b0;
            vwdat_q      <= 8'h00;
            dev_addr_q   <= 7'd0;
            cfg_q        <= 7'd0;
        end else begin
            state_q      <= state_d;
            sbuf_q       <= sbuf_d;
            idx_q        <= idx_d;
            bm_q         <= bm_d;
            breq_q       <= breq_d;
            wval_q       <= wval_d;
            widx_q       <= widx_d;
            wlen_q       <= wlen_d;
            rem_q        <= rem_d;
            total_q      <= total_d;
            off_q        <= off_d;
            base_q       <= base_d;
            use_rom_q    <= use_rom_d;
            tog_q        <= tog_d;
            tx_len_q     <= tx_len_d;
            tx_hasdata_q <= tx_hasdata_d;
            tx_data1_q   <= tx_data1_d;
            stall_q      <= stall_d;
            rx_ready_q   <= rx_ready_d;
            inl_q        <= inl_d;
            vact_q       <= vact_d;
            vreq_q       <= vreq_d;
            vval_q       <= vval_d;
            vidx_q       <= vidx_d;
            vlen_q       <= vlen_d;
            vwen_q       <= vwen_d;
            vwdat_q      <= vwdat_d;
            dev_addr_q   <= dev_addr_d;
            cfg_q        <= cfg_d;
        end
    end

    assign rx_ready         = rx_ready_q;
    assign tx_q             = use_rom_q ? descr_q : inl_q;
    assign tx_len           = tx_len_q;
    assign tx_hasdata       = tx_hasdata_q;
    assign tx_data1         = tx_data1_q;
    assign stall            = stall_q;
    assign lut_wval         = wval_q;
    assign descr_addr       = use_rom_q ? (base_q + DESCR_AW'(off_q) + DESCR_AW'(tx_addr)) : '0;
    assign vend_req_act     = vact_q;
    assign vend_req_request = vreq_q;
    assign vend_req_val     = vval_q;
    assign vend_req_idx     = vidx_q;
    assign vend_req_len     = vlen_q;
    assign vend_wr_en       = vwen_q;
    assign vend_wr_data     = vwdat_q;
    assign dev_addr         = dev_addr_q;
    assign configured       = (cfg_q != 7'd0);
endmodule

// File: tb/tb_usb2_ep0_ctrl.sv
// Bench for usb2_ep0_ctrl: request table, hand sequences for corner cases,
// and random GET_DESCRIPTOR transfers against a packet-list model.
module tb_usb2_ep0_ctrl;
    localparam int MP = 64;

    logic phy_clk = 1'b0;
    logic reset_n = 1'b0;
    logic rx_wren = 0, rx_setup = 0, rx_commit = 0;
    logic [7:0] rx_data = 0;
    logic [6:0] rx_len = 0;
    logic rx_ready;
    logic [6:0] tx_addr = 0;
    logic [7:0] tx_q;
    logic [6:0] tx_len;
    logic tx_hasdata, tx_data1;
    logic tx_ack = 0;
    logic stall;
    logic [15:0] lut_wval;
    logic lut_hit = 0;
    logic [7:0] lut_base = 0;
    logic [15:0] lut_len = 0;
    logic [7:0] descr_addr;
    logic [7:0] descr_q = 0;
    logic vend_req_act;
    logic [7:0] vend_req_request;
    logic [15:0] vend_req_val, vend_req_idx, vend_req_len;
    logic vend_wr_en;
    logic [7:0] vend_wr_data;
    logic [6:0] dev_addr;
    logic configured;

    usb2_ep0_ctrl #(.MAX_PKT(MP), .DESCR_AW(8)) dut (
        .phy_clk(phy_clk), .reset_n(reset_n),
        .rx_wren(rx_wren), .rx_data(rx_data), .rx_setup(rx_setup),
        .rx_commit(rx_commit), .rx_len(rx_len), .rx_ready(rx_ready),
        .tx_addr(tx_addr), .tx_q(tx_q), .tx_len(tx_len),
        .tx_hasdata(tx_hasdata), .tx_data1(tx_data1), .tx_ack(tx_ack),
        .stall(stall), .lut_wval(lut_wval), .lut_hit(lut_hit),
        .lut_base(lut_base), .lut_len(lut_len),
        .descr_addr(descr_addr), .descr_q(descr_q),
        .vend_req_act(vend_req_act), .vend_req_request(vend_req_request),
        .vend_req_val(vend_req_val), .vend_req_idx(vend_req_idx),
        .vend_req_len(vend_req_len), .vend_wr_en(vend_wr_en),
        .vend_wr_data(vend_wr_data), .dev_addr(dev_addr),
        .configured(configured)
    );

    always #5 phy_clk = ~phy_clk;

    function automatic logic [7:0] rom_byte(input logic [7:0] a);
        logic [7:0] t;
        t = a * 8'd37;
        return t ^ 8'hA5;
    endfunction

    always @(posedge phy_clk) descr_q <= rom_byte(descr_addr);

    logic [7:0] wr_q[$];
    always @(negedge phy_clk) if (vend_wr_en) wr_q.push_back(vend_wr_data);

    int nchk = 0, nerr = 0;
    logic [7:0] cfg_m = 8'h00;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge phy_clk);
    endtask

    task automatic commit(input logic s, input logic [6:0] l);
        rx_setup = s; rx_len = l; rx_commit = 1'b1;
        tick();
        rx_commit = 1'b0; rx_setup = 1'b0; rx_len = 7'd0;
    endtask

    task automatic send_setup(input logic [7:0] bm, input logic [7:0] breq,
                              input logic [15:0] wval, input logic [15:0] widx,
                              input logic [15:0] wlen);
        logic [7:0] b[8];
        b[0] = bm; b[1] = breq; b[2] = wval[7:0]; b[3] = wval[15:8];
        b[4] = widx[7:0]; b[5] = widx[15:8]; b[6] = wlen[7:0]; b[7] = wlen[15:8];
        for (int i = 0; i < 8; i++) begin
            rx_wren = 1'b1; rx_data = b[i];
            tick();
        end
        rx_wren = 1'b0;
        commit(1'b1, 7'd8);
    endtask

    task automatic wait_armed(output int cyc);
        cyc = 0;
        while (tx_hasdata !== 1'b1 && cyc < 12) begin
            tick();
            cyc++;
        end
    endtask

    task automatic ack();
        tx_ack = 1'b1;
        tick();
        tx_ack = 1'b0;
    endtask

    task automatic read_pkt(input int len, input int off, input bit rom,
                            input logic [7:0] breq, output int bad);
        logic [7:0] ex, ad;
        bad = 0;
        for (int a = 0; a < len; a++) begin
            tx_addr = 7'(a);
            tick();
            ad = 8'(int'(lut_base) + off + a);
            if (rom) ex = rom_byte(ad);
            else ex = (breq == 8'h08 && a == 0) ? cfg_m : 8'h00;
            if (tx_q !== ex) bad++;
        end
        tx_addr = 7'd0;
    endtask

    // Host view of an IN control transfer: expected packet lengths from the
    // byte count, ZLP rule and alternating toggles starting at DATA1.
    task automatic run_in(input logic [7:0] bm, input logic [7:0] breq,
                          input logic [15:0] wval, input logic [15:0] wlen,
                          input int ntot, input bit rom,
                          output int npk, output int len0);
        int lens[$];
        int r, off, cyc, bad;
        r = ntot;
        while (r > 0) begin
            lens.push_back(r > MP ? MP : r);
            r -= (r > MP ? MP : r);
        end
        if (ntot == 0 || (ntot % MP == 0 && ntot < int'(wlen))) lens.push_back(0);
        send_setup(bm, breq, wval, 16'h0, wlen);
        chk("rx_ready_after_commit", rx_ready, 0);
        off = 0; npk = 0; len0 = -1;
        foreach (lens[k]) begin
            wait_armed(cyc);
            chk("armed", tx_hasdata, 1);
            if (tx_hasdata !== 1'b1) break;
            if (k == 0) begin
                chk("setup_to_arm_le4", (cyc + 1 <= 4), 1);
                chk("stall_clear", stall, 0);
                len0 = int'(tx_len);
            end else begin
                chk("ack_to_rearm_2cyc", cyc, 1);
            end
            chk("tx_len", tx_len, lens[k]);
            chk("tx_data1", tx_data1, (k % 2 == 0));
            read_pkt(lens[k], off, rom, breq, bad);
            chk("pkt_bytes_bad", bad, 0);
            npk++;
            ack();
            chk("hasdata_drop", tx_hasdata, 0);
            off += lens[k];
        end
        tick(); tick(); tick();
        chk("no_extra_pkt", tx_hasdata, 0);
        commit(1'b0, 7'd0);
        tick();
        chk("rx_ready_idle", rx_ready, 1);
    endtask

    typedef struct {
        logic [7:0]  bm;
        logic [7:0]  breq;
        logic [15:0] wval;
        logic [15:0] wlen;
        logic        hit;
        logic [15:0] llen;
        logic [7:0]  base;
        logic        xstall;
        int          xnpk;
        int          xlen0;
    } vec_t;

    vec_t tv[9];

    initial begin
        int npk, len0, ntot, cyc, bad;
        logic [15:0] wl, ll;

        tv[0] = '{8'h80, 8'h06, 16'h0100, 16'd18,  1'b1, 16'd18,  8'h10, 1'b0, 1, 18};
        tv[1] = '{8'h80, 8'h06, 16'h0200, 16'd255, 1'b1, 16'd128, 8'h40, 1'b0, 3, 64};
        tv[2] = '{8'h82, 8'h0C, 16'h0000, 16'd2,   1'b0, 16'd0,   8'h00, 1'b1, 0, 0};
        tv[3] = '{8'h80, 8'h08, 16'h0000, 16'd1,   1'b0, 16'd0,   8'h00, 1'b0, 1, 1};
        tv[4] = '{8'h80, 8'h00, 16'h0000, 16'd2,   1'b0, 16'd0,   8'h00, 1'b0, 1, 2};
        tv[5] = '{8'h80, 8'h06, 16'h0300, 16'd4,   1'b0, 16'd4,   8'h00, 1'b1, 0, 0};
        tv[6] = '{8'h80, 8'h06, 16'h0100, 16'd64,  1'b1, 16'd64,  8'hF0, 1'b0, 1, 64};
        tv[7] = '{8'h80, 8'h06, 16'h0100, 16'd100, 1'b1, 16'd64,  8'h22, 1'b0, 2, 64};
        tv[8] = '{8'hA1, 8'h01, 16'h0000, 16'd4,   1'b0, 16'd0,   8'h00, 1'b1, 0, 0};

        tick(); tick();
        chk("rst_rx_ready", rx_ready, 1);
        chk("rst_tx_hasdata", tx_hasdata, 0);
        chk("rst_stall", stall, 0);
        chk("rst_dev_addr", dev_addr, 0);
        chk("rst_configured", configured, 0);
        chk("rst_tx_len", tx_len, 0);
        chk("rst_tx_q", tx_q, 0);
        chk("rst_descr_addr", descr_addr, 0);
        chk("rst_vend_act", vend_req_act, 0);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) begin
            lut_hit = tv[i].hit; lut_len = tv[i].llen; lut_base = tv[i].base;
            if (tv[i].xstall) begin
                send_setup(tv[i].bm, tv[i].breq, tv[i].wval, 16'h0, tv[i].wlen);
                tick(); tick(); tick();
                chk("tbl_stall", stall, 1);
                chk("tbl_stall_nodata", tx_hasdata, 0);
                chk("tbl_stall_rx_ready", rx_ready, 1);
            end else begin
                if (tv[i].breq == 8'h06)
                    ntot = (tv[i].wlen < tv[i].llen) ? int'(tv[i].wlen) : int'(tv[i].llen);
                else if (tv[i].breq == 8'h08)
                    ntot = (tv[i].wlen > 0) ? 1 : 0;
                else
                    ntot = (tv[i].wlen < 2) ? int'(tv[i].wlen) : 2;
                run_in(tv[i].bm, tv[i].breq, tv[i].wval, tv[i].wlen, ntot,
                       tv[i].breq == 8'h06, npk, len0);
                chk("tbl_npk", npk, tv[i].xnpk);
                chk("tbl_len0", len0, tv[i].xlen0);
            end
        end

        // SET_ADDRESS takes effect only on the status ACK
        send_setup(8'h00, 8'h05, 16'h002A, 16'h0, 16'h0);
        chk("setaddr_decode", dev_addr, 0);
        wait_armed(cyc);
        chk("setaddr_zlp_len", tx_len, 0);
        chk("setaddr_zlp_d1", tx_data1, 1);
        tick();
        chk("setaddr_before_ack", dev_addr, 0);
        ack();
        chk("setaddr_after_ack", dev_addr, 7'h2A);

        // vendor OUT request with 10-byte data stage
        send_setup(8'h40, 8'hB0, 16'h1234, 16'h5678, 16'd10);
        chk("vend_act_early", vend_req_act, 0);
        tick();
        chk("vend_act_pulse", vend_req_act, 1);
        chk("vend_request", vend_req_request, 8'hB0);
        chk("vend_val", vend_req_val, 16'h1234);
        chk("vend_idx", vend_req_idx, 16'h5678);
        chk("vend_len", vend_req_len, 16'd10);
        tick();
        chk("vend_act_off", vend_req_act, 0);
        wr_q.delete();
        for (int i = 0; i < 10; i++) begin
            rx_wren = 1'b1; rx_data = 8'(i * 17 + 3);
            tick();
        end
        rx_wren = 1'b0;
        tick();
        chk("vend_wr_count", wr_q.size(), 10);
        bad = 0;
        foreach (wr_q[i]) if (wr_q[i] !== 8'(i * 17 + 3)) bad++;
        chk("vend_wr_data_bad", bad, 0);
        commit(1'b0, 7'd10);
        wait_armed(cyc);
        chk("vend_status_len", tx_len, 0);
        chk("vend_status_d1", tx_data1, 1);
        ack();
        chk("vend_status_done", tx_hasdata, 0);

        // SET_CONFIG then GET_CONFIG
        send_setup(8'h00, 8'h09, 16'h0003, 16'h0, 16'h0);
        wait_armed(cyc);
        chk("setcfg_before_ack", configured, 0);
        ack();
        chk("setcfg_after_ack", configured, 1);
        cfg_m = 8'h03;
        run_in(8'h80, 8'h08, 16'h0, 16'd1, 1, 1'b0, npk, len0);
        chk("getcfg_npk", npk, 1);

        // new SETUP during a multi-packet IN stage
        lut_hit = 1'b1; lut_len = 16'd200; lut_base = 8'h07;
        send_setup(8'h80, 8'h06, 16'h0200, 16'h0, 16'd200);
        wait_armed(cyc);
        ack();
        wait_armed(cyc);
        chk("abort_second_pkt_d0", tx_data1, 0);
        run_in(8'h80, 8'h00, 16'h0, 16'd2, 2, 1'b0, npk, len0);
        chk("abort_new_npk", npk, 1);

        // early host status during IN data
        lut_len = 16'd18;
        send_setup(8'h80, 8'h06, 16'h0100, 16'h0, 16'd18);
        wait_armed(cyc);
        commit(1'b0, 7'd0);
        chk("early_status_drop", tx_hasdata, 0);
        tick(); tick();
        chk("early_status_idle", tx_hasdata, 0);

        // SETUP of wrong length
        commit(1'b1, 7'd5);
        tick();
        chk("badlen_stall", stall, 1);
        chk("badlen_rx_ready", rx_ready, 1);

        for (int it = 0; it < 15; it++) begin
            wl = 16'($urandom_range(1, 300));
            ll = 16'($urandom_range(1, 300));
            lut_hit = 1'b1; lut_len = ll; lut_base = 8'($urandom_range(0, 255));
            ntot = (wl < ll) ? int'(wl) : int'(ll);
            run_in(8'h80, 8'h06, 16'h0200, wl, ntot, 1'b1, npk, len0);
        end

        // asynchronous reset in the middle of a transfer
        lut_len = 16'd200;
        send_setup(8'h80, 8'h06, 16'h0200, 16'h0, 16'd200);
        wait_armed(cyc);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_hasdata", tx_hasdata, 0);
        chk("arst_dev_addr", dev_addr, 0);
        chk("arst_configured", configured, 0);
        chk("arst_tx_len", tx_len, 0);
        chk("arst_rx_ready", rx_ready, 1);
        tick();
        reset_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
